// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// flag bit offsets above the data field in rd_data, and the minimum divider.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Flag positions, counted from bit DATA_BITS of rd_data.
    localparam int FERR_OFF = 0;
    localparam int PERR_OFF = 1;
    localparam int BRK_OFF  = 2;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy output.
// Ports: push/wdata in, rdata/valid/ready out-side handshake, level, drop (push refused while full).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             full;
    logic             pop;
    logic             wr;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign level = wptr - rptr;
    assign valid = (level != '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign pop   = valid & ready;
    // A pop in the same cycle frees the slot the write lands in.
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign rdata = valid ? mem[rptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: mid-bit sampling UART receiver feeding a show-ahead FIFO.
// Ports: rx/cfg_div in; rd_data/rd_valid/rd_ready drain port; level, overrun/clr_overrun, busy.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int DEPTH      = 16,
    parameter int DIV_W      = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rx,
    input  logic [DIV_W-1:0]         cfg_div,
    output logic [DATA_BITS+2:0]     rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    input  logic                     clr_overrun,
    output logic                     busy
);

    localparam int W = DATA_BITS + 3;

    state_t               state;
    state_t               nstate;
    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic                 fall;
    logic [DIV_W-1:0]     div_eff;
    logic [DIV_W-1:0]     div_l;
    logic [DIV_W-1:0]     cnt;
    logic [3:0]           bitn;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tick;
    logic                 last_bit;
    logic                 push;
    logic                 drop;
    logic                 ferr;
    logic                 perr;
    logic                 brk;
    logic [W-1:0]         word;

    // s3 holds the previous synchronized value for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall     = s3 & ~s2;
    assign div_eff  = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
    assign tick     = (state != ST_IDLE) && (cnt == '0);
    assign last_bit = (bitn == 4'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    nstate = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    nstate = s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && last_bit) begin
                    nstate = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    nstate = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    nstate = ST_IDLE;
                end
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        push = (state == ST_STOP) && tick;
    end

    // Bit timing and data capture. Reloading with div_l-1 gives a
    // sample every div_l clocks since the zero cycle is the event itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_l   <= DIV_W'(MIN_DIV);
            cnt     <= '0;
            bitn    <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (fall) begin
                div_l <= div_eff;
                cnt   <= div_eff >> 1;
                bitn  <= '0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            cnt <= div_l - 1'b1;
            if (state == ST_DATA) begin
                shreg <= {s2, shreg[DATA_BITS-1:1]};
                bitn  <= bitn + 1'b1;
            end
            if (state == ST_PARITY) begin
                par_bit <= s2;
            end
        end
    end

    always_comb begin
        ferr = ~s2;
        brk  = ferr && (shreg == '0);
        perr = (PARITY_EN != 0) && ((^shreg ^ par_bit) != (PARITY_ODD != 0));
        word = '0;
        word[DATA_BITS-1:0]        = shreg;
        word[DATA_BITS + FERR_OFF] = ferr;
        word[DATA_BITS + PERR_OFF] = perr;
        word[DATA_BITS + BRK_OFF]  = brk;
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (word),
        .rdata  (rd_data),
        .valid  (rd_valid),
        .ready  (rd_ready),
        .level  (level),
        .drop   (drop)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: an 8N1 instance and an 8E1 instance driven
// with directed and random serial frames, checked against a frame-level model.
module tb_uart_rx_fifo;

    logic        clk;
    logic        resetn;
    logic        rx_a;
    logic        rx_b;
    logic [15:0] cfg_div_a;
    logic [15:0] cfg_div_b;
    logic [10:0] rd_data_a;
    logic [10:0] rd_data_b;
    logic        rd_valid_a;
    logic        rd_valid_b;
    logic        rd_ready_a;
    logic        rd_ready_b;
    logic [4:0]  level_a;
    logic [4:0]  level_b;
    logic        overrun_a;
    logic        overrun_b;
    logic        clr_a;
    logic        clr_b;
    logic        busy_a;
    logic        busy_b;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_b[$];

    uart_rx_fifo dut_a (
        .clk         (clk),
        .resetn      (resetn),
        .rx          (rx_a),
        .cfg_div     (cfg_div_a),
        .rd_data     (rd_data_a),
        .rd_valid    (rd_valid_a),
        .rd_ready    (rd_ready_a),
        .level       (level_a),
        .overrun     (overrun_a),
        .clr_overrun (clr_a),
        .busy        (busy_a)
    );

    uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk         (clk),
        .resetn      (resetn),
        .rx          (rx_b),
        .cfg_div     (cfg_div_b),
        .rd_data     (rd_data_b),
        .rd_valid    (rd_valid_b),
        .rd_ready    (rd_ready_b),
        .level       (level_b),
        .overrun     (overrun_b),
        .clr_overrun (clr_b),
        .busy        (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial frame as a bit list: start, data LSB first, optional parity, stop.
    function automatic void build(input logic [7:0] d, input bit pe, input bit pb,
                                  input bit stop, output logic [11:0] v, output int n);
        v = '0;
        for (int i = 0; i < 8; i++) v[1+i] = d[i];
        n = 9;
        if (pe) begin
            v[9] = pb;
            n = 10;
        end
        v[n] = stop;
        n = n + 1;
    endfunction

    // Expected FIFO entry from the frame-level rules.
    function automatic logic [10:0] entry(input logic [7:0] d, input bit pe, input bit pb,
                                          input bit stop);
        bit ferr;
        bit brk;
        bit perr;
        ferr = !stop;
        brk  = ferr && (d == 8'h00);
        perr = pe && ((($countones(d) + int'(pb)) % 2) != 0);
        return {brk, perr, ferr, d};
    endfunction

    task automatic tx_bits(input bit b, input logic [11:0] v, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            if (b) rx_b = v[i];
            else rx_a = v[i];
            repeat (div) @(negedge clk);
        end
    endtask

    task automatic idle(input bit b, input int cycles);
        if (b) rx_b = 1'b1;
        else rx_a = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pop_a(input string tag);
        logic [10:0] e;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, 32'(rd_valid_a), 32'd1);
        chk(tag, 32'(rd_data_a), 32'(e));
        rd_ready_a = 1'b1;
        @(negedge clk);
        rd_ready_a = 1'b0;
    endtask

    task automatic pop_b(input string tag);
        logic [10:0] e;
        e = exp_b.pop_front();
        chk({tag, "_valid"}, 32'(rd_valid_b), 32'd1);
        chk(tag, 32'(rd_data_b), 32'(e));
        rd_ready_b = 1'b1;
        @(negedge clk);
        rd_ready_b = 1'b0;
    endtask

    initial begin
        logic [11:0] v;
        int          n;
        int          d;
        bit          got;
        logic [7:0]  data;
        bit          stop;

        resetn     = 1'b0;
        rx_a       = 1'b1;
        rx_b       = 1'b1;
        cfg_div_a  = 16'd106;
        cfg_div_b  = 16'd40;
        rd_ready_a = 1'b0;
        rd_ready_b = 1'b0;
        clr_a      = 1'b0;
        clr_b      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rd_valid_a), 0);
        chk("rst_level", 32'(level_a), 0);
        chk("rst_overrun", 32'(overrun_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_data", 32'(rd_data_a), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Back-to-back 0x41, 0x0A with a timed second stop sample.
        build(8'h41, 0, 0, 1, v, n);
        tx_bits(0, v, n, 106);
        exp_q.push_back(entry(8'h41, 0, 0, 1));
        build(8'h0A, 0, 0, 1, v, n);
        tx_bits(0, v, 9, 106);
        rx_a = 1'b1;
        repeat (50) @(negedge clk);
        chk("b2b_early", 32'(level_a), 1);
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (level_a == 5'd2) got = 1;
        end
        chk("b2b_latency", 32'(got), 1);
        chk("b2b_busy", 32'(busy_a), 0);
        exp_q.push_back(entry(8'h0A, 0, 0, 1));
        idle(0, 120);
        pop_a("b2b_0");
        pop_a("b2b_1");

        // Short low glitch is a false start.
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy", 32'(busy_a), 1);
        repeat (20) @(negedge clk);
        idle(0, 60);
        chk("glitch_idle", 32'(busy_a), 0);
        chk("glitch_level", 32'(level_a), 0);

        // Even parity on the second instance.
        build(8'h55, 1, 1, 1, v, n);
        tx_bits(1, v, n, 40);
        exp_b.push_back(entry(8'h55, 1, 1, 1));
        idle(1, 80);
        build(8'h55, 1, 0, 1, v, n);
        tx_bits(1, v, n, 40);
        exp_b.push_back(entry(8'h55, 1, 0, 1));
        idle(1, 80);
        chk("par_level", 32'(level_b), 2);
        pop_b("par_bad");
        pop_b("par_ok");

        // Line held low for 20 bit times gives one break entry.
        rx_a = 1'b0;
        repeat (20 * 106) @(negedge clk);
        idle(0, 300);
        exp_q.push_back(entry(8'h00, 0, 0, 0));
        chk("brk_level", 32'(level_a), 1);
        pop_a("brk");
        chk("brk_empty", 32'(level_a), 0);

        // Random frames, random dividers, cfg_div scrambled mid-frame.
        for (int k = 0; k < 12; k++) begin
            d = $urandom_range(16, 40);
            data = 8'($urandom);
            stop = ($urandom % 4) != 0;
            cfg_div_a = 16'(d);
            build(data, 0, 0, stop, v, n);
            tx_bits(0, v, 1, d);
            cfg_div_a = 16'($urandom_range(2, 200));
            tx_bits(0, v >> 1, n - 1, d);
            idle(0, 2 * d);
            exp_q.push_back(entry(data, 0, 0, stop));
        end
        chk("rand_level", 32'(level_a), 32'(exp_q.size()));
        while (exp_q.size() > 0) pop_a("rand");

        // Overrun: one more frame than the FIFO holds.
        cfg_div_a = 16'd16;
        for (int k = 0; k < 17; k++) begin
            data = 8'($urandom);
            build(data, 0, 0, 1, v, n);
            tx_bits(0, v, n, 16);
            idle(0, 16);
            if (k < 16) exp_q.push_back(entry(data, 0, 0, 1));
        end
        chk("ovr_level", 32'(level_a), 16);
        chk("ovr_flag", 32'(overrun_a), 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("ovr_clear", 32'(overrun_a), 0);
        while (exp_q.size() > 0) pop_a("ovr");

        // Reset in the middle of data bits.
        cfg_div_a = 16'd106;
        build(8'h00, 0, 0, 1, v, n);
        tx_bits(0, v, 5, 106);
        resetn = 1'b0;
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_busy", 32'(busy_a), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        build(8'h7E, 0, 0, 1, v, n);
        tx_bits(0, v, n, 106);
        idle(0, 60);
        exp_q.push_back(entry(8'h7E, 0, 0, 1));
        chk("post_rst_level", 32'(level_a), 1);
        pop_a("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
